// File: rtl/cache_fill_if.sv
// Signal bundle between the cache miss controller, the cache arrays and main memory.
// master = the fill controller, slave = the cache/memory side.
interface cache_fill_if #(
    parameter int ADDR_W          = 16,
    parameter int WORDS_PER_BLOCK = 8
);
    localparam int OW = $clog2(WORDS_PER_BLOCK);

    logic              miss_detected;
    logic [ADDR_W-1:0] miss_address;
    logic              fsm_busy;
    logic              mem_read;
    logic [ADDR_W-1:0] memory_address;
    logic              memory_data_valid;
    logic [15:0]       memory_data;
    logic              write_data_array;
    logic [15:0]       cache_data;
    logic [OW-1:0]     word_index;
    logic              write_tag_array;
    logic              crit_ready;

    modport master (
        input  miss_detected, miss_address, memory_data_valid, memory_data,
        output fsm_busy, mem_read, memory_address, write_data_array,
               cache_data, word_index, write_tag_array, crit_ready
    );

    modport slave (
        output miss_detected, miss_address, memory_data_valid, memory_data,
        input  fsm_busy, mem_read, memory_address, write_data_array,
               cache_data, word_index, write_tag_array, crit_ready
    );
endinterface

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: fetches one block from pipelined memory, streams words into
// the data array, then writes the tag. Define CACHE_FILL_CRIT_WORD_FIRST_EN for critical-word-first order.
module cache_fill_fsm #(
    parameter int WORDS_PER_BLOCK = 8,
    parameter int ADDR_W          = 16
) (
    input  logic          clk,
    input  logic          rst,
    cache_fill_if.master  bus
);
    localparam int OW = $clog2(WORDS_PER_BLOCK);
    localparam int BW = ADDR_W - 1 - OW;
    localparam logic [OW:0] W_CNT = (OW+1)'(WORDS_PER_BLOCK);

    typedef enum logic [1:0] {S_IDLE, S_FILL, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_next;
    logic [BW-1:0] r_base;
    logic [OW-1:0] r_miss_word;
    logic [OW:0]   r_req_cnt;
    logic [OW:0]   r_rsp_cnt;

    logic [OW-1:0] w_start;
    logic [OW-1:0] w_req_idx;
    logic [OW-1:0] w_rsp_idx;
    logic          w_req_fire;
    logic          w_rsp_fire;

`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
    assign w_start = r_miss_word;
`else
    assign w_start = '0;
`endif

    // OW-bit adds wrap naturally modulo the block size
    assign w_req_idx = w_start + r_req_cnt[OW-1:0];
    assign w_rsp_idx = w_start + r_rsp_cnt[OW-1:0];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_base      <= '0;
            r_miss_word <= '0;
            r_req_cnt   <= '0;
            r_rsp_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            case (r_state)
                S_IDLE: begin
                    if (bus.miss_detected) begin
                        r_base      <= bus.miss_address[ADDR_W-1:OW+1];
                        r_miss_word <= bus.miss_address[OW:1];
                        r_req_cnt   <= '0;
                        r_rsp_cnt   <= '0;
                    end
                end
                S_FILL: begin
                    if (w_req_fire) r_req_cnt <= r_req_cnt + 1'b1;
                    if (w_rsp_fire) r_rsp_cnt <= r_rsp_cnt + 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        w_state_next         = r_state;
        w_req_fire           = 1'b0;
        w_rsp_fire           = 1'b0;
        bus.fsm_busy         = 1'b0;
        bus.mem_read         = 1'b0;
        bus.memory_address   = '0;
        bus.write_data_array = 1'b0;
        bus.cache_data       = '0;
        bus.word_index       = '0;
        bus.write_tag_array  = 1'b0;
        bus.crit_ready       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.miss_detected) w_state_next = S_FILL;
            end
            S_FILL: begin
                bus.fsm_busy = 1'b1;
                w_req_fire   = (r_req_cnt < W_CNT);
                bus.mem_read = w_req_fire;
                if (w_req_fire) bus.memory_address = {r_base, w_req_idx, 1'b0};
                // Responses past the end of the block are dropped
                w_rsp_fire = bus.memory_data_valid && (r_rsp_cnt < W_CNT);
                if (w_rsp_fire) begin
                    bus.write_data_array = 1'b1;
                    bus.cache_data       = bus.memory_data;
                    bus.word_index       = w_rsp_idx;
                    bus.crit_ready       = (w_rsp_idx == r_miss_word);
                    if (r_rsp_cnt == W_CNT - 1'b1) w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                bus.fsm_busy        = 1'b1;
                bus.write_tag_array = 1'b1;
                w_state_next        = S_IDLE;
            end
            default: w_state_next = S_IDLE;
        endcase
    end
endmodule

// File: tb/tb_cache_fill_fsm.sv
// Randomized bench for cache_fill_fsm with a queue-based memory and fill reference model.
module tb_cache_fill_fsm;
    localparam int W  = 8;
    localparam int OW = 3;
    localparam int L  = 4;

    logic clk = 1'b0;
    logic rst;
    int   checks = 0;
    int   errors = 0;
    int   gcyc   = 0;
    logic [15:0] salt;
    logic [15:0] pend_addr[$];
    int          pend_rdy[$];

    always #5 clk = ~clk;

    cache_fill_if #(.ADDR_W(16), .WORDS_PER_BLOCK(W)) bus ();

    cache_fill_fsm #(.WORDS_PER_BLOCK(W), .ADDR_W(16)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.master)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h (cycle %0d)", tag, got, exp, gcyc);
        end
    endtask

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return (a * 16'h9E37) ^ salt;
    endfunction

    task automatic cycle_start();
        @(posedge clk);
        #1;
        gcyc++;
    endtask

    // Memory returns queued requests in order once their latency has elapsed
    task automatic drive_mem(input bit allow, output bit v);
        v = 1'b0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = 16'($urandom);
        if (allow && pend_rdy.size() > 0 && pend_rdy[0] <= gcyc) begin
            bus.memory_data_valid = 1'b1;
            bus.memory_data       = mem_word(pend_addr.pop_front());
            void'(pend_rdy.pop_front());
            v = 1'b1;
        end
    endtask

    task automatic check_quiet(input string tag);
        check({tag, "_busy"}, bus.fsm_busy, 0);
        check({tag, "_rd"},   bus.mem_read, 0);
        check({tag, "_addr"}, bus.memory_address, 0);
        check({tag, "_wr"},   bus.write_data_array, 0);
        check({tag, "_data"}, bus.cache_data, 0);
        check({tag, "_idx"},  bus.word_index, 0);
        check({tag, "_tag"},  bus.write_tag_array, 0);
        check({tag, "_crit"}, bus.crit_ready, 0);
    endtask

    task automatic idle_cycles(input int n, input bit stray);
        bit v;
        for (int i = 0; i < n; i++) begin
            cycle_start();
            rst = 1'b0;
            bus.miss_detected = 1'b0;
            bus.miss_address  = 16'($urandom);
            drive_mem(1'b1, v);
            if (!v && stray) begin
                bus.memory_data_valid = 1'($urandom);
                bus.memory_data       = 16'($urandom);
            end
            #1;
            check_quiet("idle");
        end
        pend_addr.delete();
        pend_rdy.delete();
    endtask

    // gap_mode: 0 none, 1 random stalls, 2 three-cycle hold after the 2nd word
    task automatic do_fill(input logic [15:0] maddr, input int gap_mode, input bit toggle, input int rst_at);
        logic [15:0] exp_req[$];
        int          exp_idx[$];
        int          mw, start, idx, t, got, last_wr, gaps_done;
        logic [15:0] base;
        bit          v, allow;

        salt  = 16'($urandom);
        mw    = int'(maddr[OW:1]);
`ifdef CACHE_FILL_CRIT_WORD_FIRST_EN
        start = mw;
`else
        start = 0;
`endif
        base = 16'((int'(maddr) / (2*W)) * (2*W));
        for (int k = 0; k < W; k++) begin
            idx = (start + k) % W;
            exp_idx.push_back(idx);
            exp_req.push_back(16'(int'(base) + 2*idx));
        end

        cycle_start();
        rst = 1'b0;
        bus.miss_detected = 1'b1;
        bus.miss_address  = maddr;
        drive_mem(1'b0, v);
        #1;
        check("c0_busy", bus.fsm_busy, 0);
        check("c0_rd", bus.mem_read, 0);

        t = 1; got = 0; last_wr = -1; gaps_done = 0;
        forever begin
            cycle_start();
            rst = (t == rst_at);
            bus.miss_detected = toggle ? 1'($urandom) : 1'b0;
            bus.miss_address  = 16'($urandom);
            allow = 1'b1;
            if (gap_mode == 1) allow = ($urandom_range(3) != 0);
            if (gap_mode == 2 && got == 2 && gaps_done < 3) begin
                allow = 1'b0;
                gaps_done++;
            end
            drive_mem(allow, v);
            #1;
            if (last_wr >= 1 && t == last_wr + 1) begin
                check("done_tag", bus.write_tag_array, 1);
                check("done_busy", bus.fsm_busy, 1);
                check("done_rd", bus.mem_read, 0);
                check("done_wr", bus.write_data_array, 0);
                if (gap_mode != 1)
                    check("tag_cycle", t, W + L + 1 + ((gap_mode == 2) ? 3 : 0));
                break;
            end
            check("fill_busy", bus.fsm_busy, 1);
            check("fill_tag", bus.write_tag_array, 0);
            check("fill_rd", bus.mem_read, (t <= W) ? 1 : 0);
            if (bus.mem_read === 1'b1) begin
                if (t <= W) check("req_addr", bus.memory_address, exp_req[t-1]);
                pend_addr.push_back(bus.memory_address);
                pend_rdy.push_back(gcyc + L);
            end
            if (v) begin
                check("rsp_wr", bus.write_data_array, 1);
                check("rsp_idx", bus.word_index, exp_idx[got]);
                check("rsp_data", bus.cache_data, mem_word(exp_req[got]));
                check("rsp_crit", bus.crit_ready, (exp_idx[got] == mw) ? 1 : 0);
                got++;
                if (got == W) last_wr = t;
            end else begin
                check("gap_wr", bus.write_data_array, 0);
                check("gap_crit", bus.crit_ready, 0);
            end
            if (t == rst_at) break;
            t++;
            if (t > 200) begin
                check("timeout", t, 0);
                break;
            end
        end

        if (rst_at > 0 && t == rst_at) begin
            // Leftover responses after reset must not touch the cache
            for (int i = 0; i < 8; i++) begin
                cycle_start();
                rst = 1'b0;
                bus.miss_detected = 1'b0;
                drive_mem(1'b1, v);
                #1;
                check_quiet("post_rst");
            end
            pend_addr.delete();
            pend_rdy.delete();
        end
        $display("fill addr=%h gap=%0d toggle=%0d rst_at=%0d words=%0d cycles=%0d",
                 maddr, gap_mode, toggle, rst_at, got, t);
    endtask

    initial begin
        rst = 1'b1;
        bus.miss_detected     = 1'b0;
        bus.miss_address      = '0;
        bus.memory_data_valid = 1'b0;
        bus.memory_data       = '0;
        salt = '0;
        cycle_start();
        cycle_start();
        rst = 1'b0;
        #1;
        check_quiet("reset");

        do_fill(16'h1236, 0, 1'b0, 0);
        do_fill(16'h123A, 0, 1'b0, 0);
        do_fill(16'h0040, 0, 1'b0, 0);
        idle_cycles(4, 1'b1);
        do_fill(16'h2468, 2, 1'b0, 0);
        do_fill(16'h5A5C, 0, 1'b1, 0);
        idle_cycles(2, 1'b0);
        do_fill(16'h1236, 0, 1'b0, 6);
        do_fill(16'hFFF0, 0, 1'b0, 0);
        for (int n = 0; n < 8; n++) begin
            idle_cycles($urandom_range(2), 1'b1);
            do_fill(16'($urandom), $urandom_range(1), 1'($urandom), 0);
        end
        idle_cycles(2, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
